// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

  localparam int SERIAL_ADD_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_cell.sv
// One-bit full adder cell. Purely combinational; the controller clocks it once
// per operand bit.
module serial_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in by
// stepping a single full adder cell over WIDTH cycles, LSB first.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' port selecting
// a - b (b inverted, carry forced to 1; cout=1 means no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra bit so the counter can step past WIDTH-1 on the final RUN edge.
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, sum_reg;
  logic [WIDTH-1:0] a_sr_next, b_sr_next, sum_next;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;
  logic             cell_s, cell_co;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Operand B and initial carry as captured on an accepted start.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  serial_add_cell u_cell (
    .a  (a_sr_reg[0]),
    .b  (b_sr_reg[0]),
    .ci (carry_reg),
    .s  (cell_s),
    .co (cell_co)
  );

  // Shifted register images: operands shift right with zero fill, the result
  // shifts right taking the new cell sum at the MSB. Written per bit so that
  // WIDTH=1 degenerates cleanly to a single MSB assignment.
  assign a_sr_next[WIDTH-1] = 1'b0;
  assign b_sr_next[WIDTH-1] = 1'b0;
  assign sum_next[WIDTH-1]  = cell_s;

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_sr_next[gi] = a_sr_reg[gi+1];
      assign b_sr_next[gi] = b_sr_reg[gi+1];
      assign sum_next[gi]  = sum_reg[gi+1];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, one bit per RUN edge, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b_load;
            carry_reg <= carry_load;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
          end
        end
        RUN: begin
          a_sr_reg  <= a_sr_next;
          b_sr_reg  <= b_sr_next;
          sum_reg   <= sum_next;
          carry_reg <= cell_co;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_bit) begin
            cout_reg <= cell_co;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode directly from registers; no input reaches them combinationally.
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
